// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: FSM state encoding, parity
// mode constants and data-bit width helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // 2-bit data-bits field to bit count (5..8)
  function automatic logic [3:0] dbits_count(input logic [1:0] dbits);
    return {2'b00, dbits} + 4'd5;
  endfunction

  // Keeps only the bits that are actually transmitted
  function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Per-bit down-counter: load_i starts a bit of div_i clocks, tick_o marks its
// last clock and tick_next_o predicts tick_o for the following clock.
module uart_baud_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             tick_next_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer keeps reporting the end of a bit
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = div_i - DIV_W'(1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - DIV_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick_o      = (cnt_q == '0);
  assign tick_next_o = (cnt_d == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits) with a valid/ready byte interface and gapless frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_dbits_i,
  input  logic [1:0]       cfg_parity_i,
  input  logic             cfg_stop2_i,
  input  logic             valid_i,
  input  logic [7:0]       data_i,
  output logic             ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  logic             tx_q, busy_q, done_q;
  logic [7:0]       shift_q;
  logic [2:0]       bitcnt_q;
  logic [1:0]       dbits_q;
  logic             par_en_q, par_bit_q, stop2_q, stop_left_q;
  logic [DIV_W-1:0] div_q;

  logic             accept, tick, tick_next, tmr_load;
  logic [DIV_W-1:0] div_d, tmr_div;
  logic [7:0]       data_masked;

  assign div_d       = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
  assign data_masked = data_i & dbits_mask(cfg_dbits_i);

  assign ready_o = (state_q == ST_IDLE) || (state_q == ST_STOP && tick && !stop_left_q);
  assign accept  = valid_i && ready_o;

  // A new frame's first bit uses the divisor being latched on the same edge
  assign tmr_div  = accept ? div_d : div_q;
  assign tmr_load = accept || (busy_q && tick);

  uart_baud_timer #(.DIV_W(DIV_W)) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (tmr_load),
    .div_i       (tmr_div),
    .tick_o      (tick),
    .tick_next_o (tick_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      dbits_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      div_q       <= DIV_W'(RESET_DIV);
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q     <= ST_START;
        tx_q        <= 1'b0;
        busy_q      <= 1'b1;
        shift_q     <= data_masked;
        dbits_q     <= cfg_dbits_i;
        par_en_q    <= (cfg_parity_i == PAR_EVEN) || (cfg_parity_i == PAR_ODD);
        par_bit_q   <= (^data_masked) ^ (cfg_parity_i == PAR_ODD);
        stop2_q     <= cfg_stop2_i;
        stop_left_q <= 1'b0;
        div_q       <= div_d;
      end else begin
        case (state_q)
          ST_IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          ST_START: if (tick) begin
            state_q  <= ST_DATA;
            tx_q     <= shift_q[0];
            bitcnt_q <= 3'(dbits_count(dbits_q) - 4'd1);
          end
          ST_DATA: if (tick) begin
            if (bitcnt_q != 3'd0) begin
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
              bitcnt_q <= bitcnt_q - 3'd1;
            end else if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q     <= ST_STOP;
              tx_q        <= 1'b1;
              stop_left_q <= stop2_q;
              done_q      <= !stop2_q && tick_next;
            end
          end
          ST_PARITY: if (tick) begin
            state_q     <= ST_STOP;
            tx_q        <= 1'b1;
            stop_left_q <= stop2_q;
            done_q      <= !stop2_q && tick_next;
          end
          // done_q is raised one clock early so it lines up with the final stop clock
          ST_STOP: begin
            if (tick && stop_left_q) begin
              stop_left_q <= 1'b0;
              done_q      <= tick_next;
            end else if (tick) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              done_q <= !stop_left_q && tick_next;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: expected line waveforms come from a
// bit-list model of the frame format, expanded to one entry per clock.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] cfg_div_i = 16'd4;
  logic [1:0]  cfg_dbits_i = 2'b11;
  logic [1:0]  cfg_parity_i = 2'b00;
  logic        cfg_stop2_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        ready_o, tx_o, busy_o, done_o;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DIV_W(16), .RESET_DIV(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_div_i    (cfg_div_i),
    .cfg_dbits_i  (cfg_dbits_i),
    .cfg_parity_i (cfg_parity_i),
    .cfg_stop2_i  (cfg_stop2_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Appends one frame to exp_q: start, D data bits LSB first, optional parity, S stops
  function automatic void model(input logic [7:0] d, input int div, input int db,
                                input int par, input bit s2);
    logic bits[$];
    logic p;
    int   dv;
    dv = (div == 0) ? 1 : div;
    p  = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db + 5; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par == 1) bits.push_back(p);
    else if (par == 2) bits.push_back(~p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (dv) exp_q.push_back(bits[i]);
  endfunction

  // Presents a byte with its config and lets the next rising edge take it
  task automatic start(input logic [7:0] d, input int div, input int db, input int par,
                       input bit s2);
    @(negedge clk);
    data_i = d; cfg_div_i = 16'(div); cfg_dbits_i = 2'(db);
    cfg_parity_i = 2'(par); cfg_stop2_i = s2; valid_i = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL start_ready got %b exp 1", ready_o);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks += 4;
    if (tx_o !== 1'b1)    begin errors++; $display("FAIL reset_tx got %b exp 1", tx_o); end
    if (busy_o !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    if (done_o !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (tx_o !== 1'b1)    begin errors++; $display("FAIL post_reset_tx got %b exp 1", tx_o); end
    if (busy_o !== 1'b0)  begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_fixed_frames();
    logic [7:0] td[4]  = '{8'h55, 8'h41, 8'hFF, 8'h00};
    int         tdv[4] = '{4, 3, 2, 2};
    int         tdb[4] = '{3, 2, 0, 0};
    int         tpr[4] = '{0, 1, 2, 2};
    bit         ts2[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int         tlen[4] = '{40, 33, 16, 16};
    for (int t = 0; t < 4; t++) begin
      exp_q.delete();
      model(td[t], tdv[t], tdb[t], tpr[t], ts2[t]);
      checks++;
      if (exp_q.size() != tlen[t]) begin
        errors++; $display("FAIL fixed%0d_len got %0d exp %0d", t, exp_q.size(), tlen[t]);
      end
      start(td[t], tdv[t], tdb[t], tpr[t], ts2[t]);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        if (k == 0) valid_i = 1'b0;
        checks += 4;
        if (tx_o !== exp_q[k]) begin errors++; $display("FAIL fixed%0d_tx cyc %0d got %b exp %b", t, k + 1, tx_o, exp_q[k]); end
        if (busy_o !== 1'b1) begin errors++; $display("FAIL fixed%0d_busy cyc %0d got %b exp 1", t, k + 1, busy_o); end
        if (done_o !== (k == exp_q.size() - 1)) begin errors++; $display("FAIL fixed%0d_done cyc %0d got %b", t, k + 1, done_o); end
        if (ready_o !== (k == exp_q.size() - 1)) begin errors++; $display("FAIL fixed%0d_ready cyc %0d got %b", t, k + 1, ready_o); end
      end
      @(negedge clk);
      checks += 3;
      if (tx_o !== 1'b1)    begin errors++; $display("FAIL fixed%0d_idle_tx got %b exp 1", t, tx_o); end
      if (busy_o !== 1'b0)  begin errors++; $display("FAIL fixed%0d_idle_busy got %b exp 0", t, busy_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL fixed%0d_idle_ready got %b exp 1", t, ready_o); end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    model(8'hA5, 3, 3, 0, 1'b0);
    model(8'h3C, 3, 3, 0, 1'b0);
    start(8'hA5, 3, 3, 0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) data_i = 8'h3C;
      if (k == 30) valid_i = 1'b0;
      checks += 4;
      if (tx_o !== exp_q[k]) begin errors++; $display("FAIL b2b_tx cyc %0d got %b exp %b", k + 1, tx_o, exp_q[k]); end
      if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp 1", k + 1, busy_o); end
      if (done_o !== (k == 29 || k == 59)) begin errors++; $display("FAIL b2b_done cyc %0d got %b", k + 1, done_o); end
      if (ready_o !== (k == 29 || k == 59)) begin errors++; $display("FAIL b2b_ready cyc %0d got %b", k + 1, ready_o); end
    end
    @(negedge clk);
    checks += 2;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy_o); end
    if (tx_o !== 1'b1)   begin errors++; $display("FAIL b2b_idle_tx got %b exp 1", tx_o); end
  endtask

  task automatic test_cfg_change();
    for (int f = 0; f < 2; f++) begin
      exp_q.delete();
      if (f == 0) begin
        model(8'h96, 4, 3, 0, 1'b0);
        start(8'h96, 4, 3, 0, 1'b0);
      end else begin
        model(8'h5A, 2, 3, 1, 1'b0);
        @(negedge clk);
        data_i = 8'h5A; valid_i = 1'b1;
        @(posedge clk);
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        if (k == 0) valid_i = 1'b0;
        if (f == 0 && k == 1) begin cfg_div_i = 16'd2; cfg_parity_i = 2'b01; end
        checks += 2;
        if (tx_o !== exp_q[k]) begin errors++; $display("FAIL cfgchg%0d_tx cyc %0d got %b exp %b", f, k + 1, tx_o, exp_q[k]); end
        if (done_o !== (k == exp_q.size() - 1)) begin errors++; $display("FAIL cfgchg%0d_done cyc %0d got %b", f, k + 1, done_o); end
      end
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL cfgchg%0d_idle_busy got %b exp 0", f, busy_o); end
    end
  endtask

  task automatic test_reset_mid_frame();
    start(8'h00, 4, 3, 0, 1'b0);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) valid_i = 1'b0;
    end
    checks += 2;
    if (tx_o !== 1'b0)   begin errors++; $display("FAIL midrst_pre_tx got %b exp 0", tx_o); end
    if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b exp 1", busy_o); end
    #1 resetn = 1'b0;
    #1;
    checks += 3;
    if (tx_o !== 1'b1)    begin errors++; $display("FAIL midrst_tx got %b exp 1", tx_o); end
    if (busy_o !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b exp 0", busy_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", ready_o); end
    #1 resetn = 1'b1;
    exp_q.delete();
    model(8'h81, 0, 3, 0, 1'b0);
    start(8'h81, 0, 3, 0, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) valid_i = 1'b0;
      checks += 2;
      if (tx_o !== exp_q[k]) begin errors++; $display("FAIL div0_tx cyc %0d got %b exp %b", k + 1, tx_o, exp_q[k]); end
      if (done_o !== (k == 9)) begin errors++; $display("FAIL div0_done cyc %0d got %b", k + 1, done_o); end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL div0_idle_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int dv, db, pr;
    bit s2;
    for (int f = 0; f < 30; f++) begin
      d  = 8'($urandom);
      dv = $urandom_range(0, 4);
      db = $urandom_range(0, 3);
      pr = $urandom_range(0, 3);
      s2 = 1'($urandom);
      exp_q.delete();
      model(d, dv, db, pr, s2);
      start(d, dv, db, pr, s2);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        valid_i = 1'b0;
        data_i = 8'($urandom); cfg_div_i = 16'($urandom_range(0, 5));
        cfg_dbits_i = 2'($urandom); cfg_parity_i = 2'($urandom); cfg_stop2_i = 1'($urandom);
        checks += 3;
        if (tx_o !== exp_q[k]) begin errors++; $display("FAIL rnd%0d_tx cyc %0d got %b exp %b", f, k + 1, tx_o, exp_q[k]); end
        if (busy_o !== 1'b1) begin errors++; $display("FAIL rnd%0d_busy cyc %0d got %b exp 1", f, k + 1, busy_o); end
        if (done_o !== (k == exp_q.size() - 1)) begin errors++; $display("FAIL rnd%0d_done cyc %0d got %b", f, k + 1, done_o); end
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_busy got %b exp 0", f, busy_o); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_frames();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter and successor to the fixed 8N1 transmitter. Supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and a runtime baud divisor. Uses a valid/ready byte handshake that allows zero-gap back-to-back frames. Sits between the host-side byte source (register block or FIFO) and the serial pin.

Parameters:
DIV_W, 16, width of the clocks-per-bit divisor input
RESET_DIV, 4, informational only; no internal use (divisor always comes from cfg_div_i)

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
cfg_div_i  in  DIV_W  clocks per bit; 0 is treated as 1
cfg_dbits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_parity_i  in  2  00=none, 01=even, 10=odd, 11=none
cfg_stop2_i  in  1  0=one stop bit, 1=two stop bits
valid_i  in  1  byte available on data_i
data_i  in  8  byte to send, LSB first; bits above dbits ignored
ready_o  out  1  block accepts a byte this cycle
tx_o  out  1  serial line, idle high, registered
busy_o  out  1  frame in progress, registered
done_o  out  1  one-cycle pulse in last clock of final stop bit, registered

Behaviour:
- Reset (async assert, sync release): state IDLE, tx_o=1, busy_o=0, done_o=0, ready_o=1, bit timer and counters cleared. Reset mid-frame aborts the frame; tx_o returns high immediately without waiting for a clock edge.
- Transfer: occurs on a rising edge with valid_i & ready_o. On that edge the block latches data_i, cfg_div_i (0→1), cfg_dbits_i, cfg_parity_i and cfg_stop2_i. Config changes later in the frame have no effect on it.
- Latency: tx_o=0 (start bit) from the clock after the transfer edge.
- Bit period: every bit is exactly div clocks. Frame length = div*(1+D+P+S) clocks, where P∈{0,1} and S∈{1,2}.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: tx_o=1, ready_o=1, busy_o=0.
  - START: tx_o=0 for div clocks.
  - DATA: tx_o=shift[0] for div clocks per bit, shifting right; leave after D bits.
  - PARITY: entered only if parity is enabled. Even: tx_o = XOR of the D data bits. Odd: inverse of even.
  - STOP: tx_o=1 for S*div clocks.
- ready_o = (state==IDLE) OR (state==STOP AND last clock of final stop bit). ready_o is combinational from registered state and timer.
- Back-to-back: a transfer during the last STOP clock goes straight to START. The stop bit is exactly S*div clocks with no extra idle clock. Otherwise the FSM returns to IDLE.
- busy_o=1 in START/DATA/PARITY/STOP. busy_o stays 1 across a back-to-back boundary.
- done_o pulses for the final stop clock of every frame, including back-to-back frames.
- Bit timer: down-counter loaded with div-1 at each bit start. Bit end is when the counter reaches 0. The counter never wraps below 0. With div=1 every state lasts one clock.
- Illegal state encoding: go to IDLE with tx_o=1.

Decomposition:
- Package uart_pkg:
  - state encodings (IDLE, START, DATA, PARITY, STOP)
  - parity mode constants (PAR_NONE=00, PAR_EVEN=01, PAR_ODD=10)
  - dbits encoding helper (dbits+5)
- Sub-module uart_baud_timer:
  - inputs load_i, div_i; output tick_o at the last clock of a bit period
  - reused by the future configurable receiver

Test Plan:
1. div=4, 8N1, send 0x55 → tx_o after start: 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks; done_o at clock 40 after transfer; ready_o high at clock 40.
2. div=3, 7E2, send 0x41 → data bits 1,0,0,0,0,0,1, parity 0, two stop bits; frame 33 clocks; bit 7 of data_i never appears.
3. div=2, 5O1, send 0xFF → five 1s, parity 0, frame 16 clocks; then 5O1 send 0x00 → parity 1.
4. div=3, 8N1, valid_i held high with 0xA5 then 0x3C → second start bit begins the clock after the first frame's last stop clock; busy_o never drops; ready_o high exactly one clock between frames; two done_o pulses 30 clocks apart.
5. Start 8N1 at div=4, change cfg_div_i to 2 and cfg_parity_i to even mid-frame → frame still 40 clocks, no parity bit; next frame uses div=2 with even parity.
6. Assert resetn low during data bit 3 with no clock edge → tx_o=1 and busy_o=0 immediately. After release, send 0x81 with cfg_div_i=0 → each bit 1 clock, frame 10 clocks.
